tc2sm_serial: RTL and testbench
===============================

# tc2sm_serial

Sequential slice-serial converter from two's-complement to sign-magnitude. It takes a signed multiplier product, or any signed WIDTH-bit word, and returns its sign and its unsigned magnitude. Negation is done LSB-first, STEP bits per cycle, with an OR-accumulator that carries across slices: bit i = x_i XOR (x_0 | … | x_{i-1}). The block sits after the Booth-4/Wallace 16×16 multiplier, where the final product is converted back to sign-magnitude for downstream consumers. Valid/ready handshakes are used on both sides.

## Interface

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of STEP.
- STEP, 4, bits processed per cycle; N = WIDTH/STEP slices per conversion.

Ports:
- sys_clk  in  1  clock; all logic is on the rising edge.
- sys_rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept an input; high only in IDLE.
- in_data  in  WIDTH  two's-complement input word.
- out_valid  out  1  result is valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- out_sign  out  1  sign of the input (in_data[WIDTH-1]).
- out_mag  out  WIDTH  unsigned magnitude |in_data|.

## Operation

- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid & in_ready: latch in_data into src, set sign=in_data[WIDTH-1], clear or_acc=0 and slice counter cnt=0, then go to CONV.
- CONV:
  - Each cycle, process slice cnt, i.e. bits [cnt*STEP +: STEP].
  - Per bit i in ascending order:
    - mag_i = sign ? (src_i ^ run) : src_i, where run = or_acc | (OR of the lower bits of src within this slice).
    - Write mag_i into the result register.
  - Update or_acc with the OR of all src bits of the slice.
  - Increment cnt.
  - When cnt==N-1 is processed, go to DONE.
- DONE:
  - out_valid=1.
  - out_sign and out_mag hold stable until out_valid & out_ready, then go to IDLE.
- Width rule:
  - out_mag is unsigned WIDTH bits, so the most-negative input (1 followed by zeros) maps to magnitude 2^(WIDTH-1) with no overflow.
  - Zero input gives sign 0 and magnitude 0.
- Positive inputs take the same N-cycle path as negative ones. Latency is constant and data-independent.
- in_valid and in_data are ignored outside IDLE. There is no queuing; the source must hold in_valid until in_ready.
- Only one conversion is ever in flight; there is no input buffer beyond src.
- out_mag is don't-care while out_valid=0. out_sign and out_mag must not change while out_valid=1.

## Timing

- Reset (sys_rst_n low at a rising edge):
  - state=IDLE, cnt=0, or_acc=0, sign=0, src=0, result=0.
  - Outputs after that edge: out_valid=0, out_sign=0, out_mag=0, in_ready=1.
- Reset mid-operation, in CONV or DONE: the conversion is abandoned with no output handshake. The next cycle is IDLE with the reset values above.
- Latency: input accepted at edge T → out_valid=1 from edge T+N onward. With WIDTH=32, STEP=4 that is 8 cycles.
- Output handshake at edge U → IDLE at U, in_ready=1 in the cycle after U. The next accept is at the earliest at U+1.
- Best-case throughput is one word per N+2 cycles.
- No combinational path from in_valid or out_ready to any output. in_ready and out_valid are decoded from registered state only.
- Back-pressure: out_ready low in DONE holds the state indefinitely.

## Test plan

All scenarios use WIDTH=32, STEP=4.

- Accept 0x0000_0005 at edge T → out_valid rises at T+8, out_sign=0, out_mag=0x0000_0005; in_ready=0 from T to the handshake.
- 0xFFFF_FFFB (−5) → out_sign=1, out_mag=0x0000_0005.
- 0xFFFF_FFF0 (−16; low slice all zero, so the OR carry must propagate across slices) → out_sign=1, out_mag=0x0000_0010.
- Single-bit and extreme inputs:
  - 0x8000_0000 → out_sign=1, out_mag=0x8000_0000.
  - 0x0000_0000 → 0 / 0x0000_0000.
  - 0x7FFF_FFFF → 0 / 0x7FFF_FFFF.
- Hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new data → outputs stable, in_ready=0, new data not taken. Raise out_ready → handshake, then the new word is accepted the cycle after IDLE is re-entered.
- Pull sys_rst_n low for one edge at the 3rd CONV cycle of 0xFFFF_FFFB → next cycle out_valid=0, out_mag=0, in_ready=1. Then accept 0x0000_0009 → 0 / 0x0000_0009 after 8 cycles, with no residue from the aborted word.

Source files
------------

// File: rtl/tc2sm_serial.sv
// -----------------------------------------------------------------------------
// tc2sm_serial
//
// Slice-serial two's-complement to sign-magnitude converter. A word accepted
// in IDLE is negated (when negative) LSB-first, STEP bits per cycle, using a
// running OR of the lower source bits:
//
//   mag_i = sign ? x_i ^ (x_0 | ... | x_{i-1}) : x_i
//
// The OR carry crosses slice boundaries through r_or_acc. Latency is a fixed
// N = WIDTH/STEP cycles from accept to out_valid, regardless of data.
//
// States:
//   S_IDLE | waiting for an input word, in_ready=1
//   S_CONV | processing slice r_cnt, one slice per cycle
//   S_DONE | result presented, out_valid=1, held until out_ready
//
// Ports:
//   sys_clk    in   clock, rising edge
//   sys_rst_n  in   synchronous active-low reset
//   in_valid   in   in_data is valid
//   in_ready   out  block accepts input (IDLE only)
//   in_data    in   WIDTH-bit two's-complement word
//   out_valid  out  result valid (DONE only)
//   out_ready  in   consumer accepts result
//   out_sign   out  sign of accepted word
//   out_mag    out  WIDTH-bit unsigned magnitude
// -----------------------------------------------------------------------------
module tc2sm_serial #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [WIDTH-1:0]  r_src;
    logic              r_sign;
    logic              r_or_acc;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_result;

    logic              w_accept;
    logic              w_step;
    logic [STEP-1:0]   w_slice;
    logic [STEP-1:0]   w_mag;
    logic              w_run;
    logic              w_or_next;
    logic [WIDTH-1:0]  w_result_next;

    // Slice select as a constant-index mux so every part-select is static.
    always_comb begin
        w_slice = '0;
        for (int s = 0; s < N; s++) begin
            if (r_cnt == CW'(s)) begin
                w_slice = r_src[s*STEP +: STEP];
            end
        end
    end

    // Within a slice the running OR starts from the carry of all lower
    // slices, then picks up each source bit after that bit is converted.
    always_comb begin
        w_mag = '0;
        w_run = r_or_acc;
        for (int b = 0; b < STEP; b++) begin
            w_mag[b] = r_sign ? (w_slice[b] ^ w_run) : w_slice[b];
            w_run    = w_run | w_slice[b];
        end
        w_or_next = r_or_acc | (|w_slice);
    end

    always_comb begin
        w_result_next = r_result;
        for (int s = 0; s < N; s++) begin
            if (r_cnt == CW'(s)) begin
                w_result_next[s*STEP +: STEP] = w_mag;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_CONV;
                end
            end
            S_CONV: begin
                w_step = 1'b1;
                if (r_cnt == LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state  <= S_IDLE;
            r_src    <= '0;
            r_sign   <= 1'b0;
            r_or_acc <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_src    <= in_data;
                r_sign   <= in_data[WIDTH-1];
                r_or_acc <= 1'b0;
                r_cnt    <= '0;
            end
            if (w_step) begin
                r_result <= w_result_next;
                r_or_acc <= w_or_next;
                // Explicit wrap keeps the counter correct when N is not a power of two.
                r_cnt    <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
            end
        end
    end

    // Handshake outputs decode registered state only.
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_sign  = r_sign;
    assign out_mag   = r_result;

endmodule

// File: tb/tb_tc2sm_serial.sv
module tb_tc2sm_serial;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [31:0] out_mag;

    int n_asserts;
    int n_fail;
    int cycles;

    tc2sm_serial #(.WIDTH(32), .STEP(4)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_mag   (out_mag)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one word while IDLE; returns #1 after the accept edge.
    task automatic start(input string tag, input logic [31:0] d);
        check({tag, " in_ready before accept"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge sys_clk);
        #1;
        in_valid = 1'b0;
        in_data  = 32'h0;
    endtask

    // Counts cycles from the accept edge until out_valid is seen; bounded.
    task automatic wait_done(input string tag);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 20) begin
            check({tag, " in_ready low while busy"}, {31'd0, in_ready}, 32'd0);
            @(posedge sys_clk);
            #1;
            cycles++;
        end
        check({tag, " latency"}, cycles, 32'd8);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        out_ready = 1'b0;
        check({tag, " in_ready after handshake"}, {31'd0, in_ready}, 32'd1);
        check({tag, " out_valid after handshake"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic convert(input string tag, input logic [31:0] d,
                           input logic exp_sign, input logic [31:0] exp_mag);
        start(tag, d);
        wait_done(tag);
        check({tag, " sign"}, {31'd0, out_sign}, {31'd0, exp_sign});
        check({tag, " mag"}, out_mag, exp_mag);
        handshake(tag);
    endtask

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        sys_rst_n = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;

        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_sign", {31'd0, out_sign}, 32'd0);
        check("reset out_mag", out_mag, 32'h0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);

        convert("pos5",   32'h0000_0005, 1'b0, 32'h0000_0005);
        convert("neg5",   32'hFFFF_FFFB, 1'b1, 32'h0000_0005);
        convert("neg16",  32'hFFFF_FFF0, 1'b1, 32'h0000_0010);
        convert("minneg", 32'h8000_0000, 1'b1, 32'h8000_0000);
        convert("zero",   32'h0000_0000, 1'b0, 32'h0000_0000);
        convert("maxpos", 32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF);
        convert("neg1",   32'hFFFF_FFFF, 1'b1, 32'h0000_0001);
        convert("mixed",  32'hF0F0_0100, 1'b1, 32'h0F0F_FF00);

        // Back-pressure: result held while a new word waits at the input.
        start("bp", 32'h0000_1234);
        wait_done("bp");
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        for (int k = 0; k < 5; k++) begin
            @(posedge sys_clk);
            #1;
            check("bp hold out_valid", {31'd0, out_valid}, 32'd1);
            check("bp hold in_ready", {31'd0, in_ready}, 32'd0);
            check("bp hold sign", {31'd0, out_sign}, 32'd0);
            check("bp hold mag", out_mag, 32'h0000_1234);
        end
        out_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        out_ready = 1'b0;
        check("bp in_ready after handshake", {31'd0, in_ready}, 32'd1);
        check("bp out_valid after handshake", {31'd0, out_valid}, 32'd0);
        @(posedge sys_clk);
        #1;
        in_valid = 1'b0;
        in_data  = 32'h0;
        wait_done("bp new");
        check("bp new sign", {31'd0, out_sign}, 32'd1);
        check("bp new mag", out_mag, 32'h2152_4111);
        handshake("bp new");

        // Reset at the third CONV edge abandons the word.
        start("abort", 32'hFFFF_FFFB);
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        check("abort out_mag", out_mag, 32'h0);
        check("abort out_sign", {31'd0, out_sign}, 32'd0);
        check("abort in_ready", {31'd0, in_ready}, 32'd1);
        convert("after abort", 32'h0000_0009, 1'b0, 32'h0000_0009);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
